// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: instruction width, the
// encoding used for a bubble in IF/ID, and the fetch FSM state type.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int INSTR_W = 32;

    // All-zero word is treated as a NOP by decode, so bubbles carry this value.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // RUN  : request issued, first cycle of the fetch
    // WAIT : request still outstanding because memory has not accepted it
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// ----------------------------------------------------------------------------
// fetch_pc_next
// Combinational selection of the nPC value to load on an accepted fetch.
// A redirect arriving this cycle takes priority over one parked in the
// pending register; with neither present the nPC simply advances by 4.
//
// Ports
//   npc             in   current architectural nPC
//   redirect        in   fresh redirect from decode this cycle
//   redirect_target in   destination of the fresh redirect (byte address)
//   annul           in   fresh annul qualifier for the fresh redirect
//   pend_v          in   a redirect is parked in the pending register
//   pend_an         in   parked annul qualifier
//   pend_tgt        in   parked redirect destination
//   npc_next        out  value for nPC on the accepting edge
//   eff_annul       out  annul is in force (only ever with a redirect)
// ----------------------------------------------------------------------------
module fetch_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        annul,
    input  logic        pend_v,
    input  logic        pend_an,
    input  logic [31:0] pend_tgt,
    output logic [31:0] npc_next,
    output logic        eff_annul
);

    logic        eff_redirect;
    logic [31:0] sel_tgt;
    logic        sel_an;

    // Pick the redirect source (fresh wins over pending), then force word
    // alignment on the target. Annul without any redirect is meaningless and
    // is dropped here so the register logic never has to think about it.
    always_comb begin
        eff_redirect = 1'b0;
        sel_tgt      = 32'h0000_0000;
        sel_an       = 1'b0;
        if (redirect) begin
            eff_redirect = 1'b1;
            sel_tgt      = redirect_target;
            sel_an       = annul;
        end else if (pend_v) begin
            eff_redirect = 1'b1;
            sel_tgt      = pend_tgt;
            sel_an       = pend_an;
        end
        npc_next  = eff_redirect ? (sel_tgt & 32'hFFFF_FFFC) : (npc + 32'd4);
        eff_annul = eff_redirect & sel_an;
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with a SPARC-style PC/nPC pair and one delay slot.
// Issues one request per cycle to instruction memory, waits while memory is
// not ready, and registers the fetched word into the IF/ID pipeline register.
//
// Ports
//   clk             in   clock, all state changes on the rising edge
//   rst_n           in   synchronous active-low reset
//   stall           in   load-use hold: freezes PC, nPC, IF/ID and the FSM
//   redirect        in   branch taken / call / jmpl from decode
//   redirect_target in   redirect destination byte address
//   annul           in   squash the delay-slot instruction (with redirect)
//   imem_req        out  instruction memory request
//   imem_addr       out  fetch address (always the current PC)
//   imem_ready      in   memory accepts the request, imem_data valid now
//   imem_data       in   fetched instruction word
//   if_id_instr     out  registered instruction for decode (0 = NOP)
//   if_id_pc        out  address of if_id_instr
//   if_id_valid     out  if_id_instr is a real, non-squashed instruction
//   pc, npc         out  architectural PC/nPC for link values
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               annul,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic               if_id_valid,
    output logic [31:0]        pc,
    output logic [31:0]        npc
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] npc_q;
    logic        pend_v;
    logic        pend_an;
    logic [31:0] pend_tgt;
    logic        squash_q;
    logic        accept;
    logic [31:0] npc_next;
    logic        eff_annul;

    fetch_pc_next u_pc_next (
        .npc             (npc_q),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .annul           (annul),
        .pend_v          (pend_v),
        .pend_an         (pend_an),
        .pend_tgt        (pend_tgt),
        .npc_next        (npc_next),
        .eff_annul       (eff_annul)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign npc       = npc_q;
    assign accept    = imem_req & imem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request. The request is gated by rst_n directly so a
    // reset arriving mid-WAIT withdraws the request in that same cycle.
    // Stall freezes the FSM and withdraws the request.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            RUN, WAIT: begin
                imem_req = rst_n & ~stall;
                if (!stall) begin
                    state_d = accept ? RUN : WAIT;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // PC/nPC, IF/ID, pending redirect and delay-slot squash flag.
    // A redirect seen on a non-accept cycle is parked so it is not lost while
    // memory is busy. When an annulling redirect is taken, the squash flag
    // marks the following accepted word (the delay slot) to enter IF/ID as a
    // bubble, while PC/nPC continue to advance normally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC + 32'd4;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0000_0000;
            if_id_valid <= 1'b0;
            pend_v      <= 1'b0;
            pend_an     <= 1'b0;
            pend_tgt    <= 32'h0000_0000;
            squash_q    <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                pc_q     <= npc_q;
                npc_q    <= npc_next;
                if_id_pc <= pc_q;
                if (squash_q) begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end else begin
                    if_id_instr <= imem_data;
                    if_id_valid <= 1'b1;
                end
                squash_q <= eff_annul;
                pend_v   <= 1'b0;
            end else begin
                if_id_instr <= NOP_INSTR;
                if_id_pc    <= pc_q;
                if_id_valid <= 1'b0;
                if (redirect) begin
                    pend_v   <= 1'b1;
                    pend_an  <= annul;
                    pend_tgt <= redirect_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Two instances share all inputs: one with the
// default reset PC and one starting near the top of the address space to
// exercise wrap-around. Memory returns address ^ 32'h5A5A_0000 as data.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        annul;
    logic        imem_ready;

    logic        imem_req,   hi_imem_req;
    logic [31:0] imem_addr,  hi_imem_addr;
    logic [31:0] imem_data,  hi_imem_data;
    logic [31:0] if_id_instr, hi_if_id_instr;
    logic [31:0] if_id_pc,   hi_if_id_pc;
    logic        if_id_valid, hi_if_id_valid;
    logic [31:0] pc,         hi_pc;
    logic [31:0] npc,        hi_npc;

    int err_count   = 0;
    int check_count = 0;

    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

    assign imem_data    = imem_addr ^ DATA_KEY;
    assign hi_imem_data = hi_imem_addr ^ DATA_KEY;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .annul           (annul),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_data       (imem_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .pc              (pc),
        .npc             (npc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .annul           (annul),
        .imem_req        (hi_imem_req),
        .imem_addr       (hi_imem_addr),
        .imem_ready      (imem_ready),
        .imem_data       (hi_imem_data),
        .if_id_instr     (hi_if_id_instr),
        .if_id_pc        (hi_if_id_pc),
        .if_id_valid     (hi_if_id_valid),
        .pc              (hi_pc),
        .npc             (hi_npc)
    );

    function automatic logic [31:0] inst(input logic [31:0] a);
        return a ^ DATA_KEY;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd,
                                 input logic [31:0] tgt, input logic an,
                                 input logic rdy);
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        annul           = an;
        imem_ready      = rdy;
    endtask

    // Advance past one rising edge; outputs are sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        #1;
        // Reset state
        checkOutput("rst_pc",        pc,          32'h0000_0000);
        checkOutput("rst_npc",       npc,         32'h0000_0004);
        checkOutput("rst_instr",     if_id_instr, 32'h0000_0000);
        checkOutput("rst_ifid_pc",   if_id_pc,    32'h0000_0000);
        checkOutput("rst_valid",     if_id_valid, 32'h0);
        checkOutput("rst_req",       imem_req,    32'h0);
        checkOutput("rst_hi_pc",     hi_pc,       32'hFFFF_FFF8);
        checkOutput("rst_hi_npc",    hi_npc,      32'hFFFF_FFFC);

        // Streaming with imem_ready high
        rst_n = 1'b1;
        #1;
        checkOutput("run_req",       imem_req,    32'h1);
        checkOutput("run_addr0",     imem_addr,   32'h0000_0000);
        tick();
        checkOutput("run_addr4",     imem_addr,   32'h0000_0004);
        checkOutput("run_ifid_pc0",  if_id_pc,    32'h0000_0000);
        checkOutput("run_instr0",    if_id_instr, inst(32'h0));
        checkOutput("run_valid0",    if_id_valid, 32'h1);
        tick();
        checkOutput("run_addr8",     imem_addr,   32'h0000_0008);
        checkOutput("run_ifid_pc4",  if_id_pc,    32'h0000_0004);

        // Redirect to 0x100 while accepting at PC=8, no annul
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("br_addrC",      imem_addr,   32'h0000_000C);
        checkOutput("br_npc",        npc,         32'h0000_0100);
        checkOutput("br_ifid_pc8",   if_id_pc,    32'h0000_0008);
        tick();
        checkOutput("br_addr100",    imem_addr,   32'h0000_0100);
        checkOutput("br_slot_pc",    if_id_pc,    32'h0000_000C);
        checkOutput("br_slot_instr", if_id_instr, inst(32'hC));
        checkOutput("br_slot_valid", if_id_valid, 32'h1);
        tick();
        checkOutput("br_addr104",    imem_addr,   32'h0000_0104);
        checkOutput("br_ifid_pc100", if_id_pc,    32'h0000_0100);

        // Same redirect with annul: delay slot at 0xC becomes a bubble
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("an_addr0",      imem_addr,   32'h0000_0000);
        tick();
        tick();
        checkOutput("an_addr8",      imem_addr,   32'h0000_0008);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("an_br_valid",   if_id_valid, 32'h1);
        checkOutput("an_br_instr",   if_id_instr, inst(32'h8));
        checkOutput("an_addrC",      imem_addr,   32'h0000_000C);
        tick();
        checkOutput("an_addr100",    imem_addr,   32'h0000_0100);
        checkOutput("an_slot_pc",    if_id_pc,    32'h0000_000C);
        checkOutput("an_slot_instr", if_id_instr, 32'h0000_0000);
        checkOutput("an_slot_valid", if_id_valid, 32'h0);
        tick();
        checkOutput("an_addr104",    imem_addr,   32'h0000_0104);
        checkOutput("an_tgt_pc",     if_id_pc,    32'h0000_0100);
        checkOutput("an_tgt_valid",  if_id_valid, 32'h1);

        // Memory not ready for 3 cycles, redirect to 0x203 pulsed in cycle 1
        applyStimulus(1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
        #1;
        checkOutput("wt_req",        imem_req,    32'h1);
        checkOutput("wt_addr_c1",    imem_addr,   32'h0000_0104);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("wt_addr_c2",    imem_addr,   32'h0000_0104);
        checkOutput("wt_bub1_valid", if_id_valid, 32'h0);
        checkOutput("wt_bub1_instr", if_id_instr, 32'h0000_0000);
        checkOutput("wt_bub1_pc",    if_id_pc,    32'h0000_0104);
        tick();
        checkOutput("wt_addr_c3",    imem_addr,   32'h0000_0104);
        checkOutput("wt_bub2_valid", if_id_valid, 32'h0);
        tick();
        checkOutput("wt_addr_c4",    imem_addr,   32'h0000_0104);
        checkOutput("wt_bub3_valid", if_id_valid, 32'h0);
        checkOutput("wt_hold_npc",   npc,         32'h0000_0108);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("wt_req_acc",    imem_req,    32'h1);
        tick();
        checkOutput("wt_acc_pc",     pc,          32'h0000_0108);
        checkOutput("wt_acc_npc",    npc,         32'h0000_0200);
        checkOutput("wt_acc_ifpc",   if_id_pc,    32'h0000_0104);
        checkOutput("wt_acc_instr",  if_id_instr, inst(32'h104));
        checkOutput("wt_acc_valid",  if_id_valid, 32'h1);
        tick();
        checkOutput("wt_addr200",    imem_addr,   32'h0000_0200);
        checkOutput("wt_ifpc108",    if_id_pc,    32'h0000_0108);

        // Stall for 2 cycles with redirect/annul asserted: all ignored
        applyStimulus(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b1);
        #1;
        checkOutput("st_req0",       imem_req,    32'h0);
        tick();
        checkOutput("st_pc1",        pc,          32'h0000_0200);
        checkOutput("st_ifpc1",      if_id_pc,    32'h0000_0108);
        checkOutput("st_valid1",     if_id_valid, 32'h1);
        checkOutput("st_req1",       imem_req,    32'h0);
        tick();
        checkOutput("st_pc2",        pc,          32'h0000_0200);
        checkOutput("st_npc2",       npc,         32'h0000_0204);
        checkOutput("st_instr2",     if_id_instr, inst(32'h108));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("st_req_res",    imem_req,    32'h1);
        checkOutput("st_addr_res",   imem_addr,   32'h0000_0200);
        tick();
        checkOutput("st_res_pc",     pc,          32'h0000_0204);
        checkOutput("st_res_npc",    npc,         32'h0000_0208);
        checkOutput("st_res_ifpc",   if_id_pc,    32'h0000_0200);
        checkOutput("st_res_valid",  if_id_valid, 32'h1);

        // High reset PC: wrap-around, then reset mid-WAIT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("hi_addr_f8",    hi_imem_addr, 32'hFFFF_FFF8);
        tick();
        checkOutput("hi_addr_fc",    hi_imem_addr, 32'hFFFF_FFFC);
        checkOutput("hi_npc_wrap",   hi_npc,       32'h0000_0000);
        checkOutput("hi_ifpc_f8",    hi_if_id_pc,  32'hFFFF_FFF8);
        tick();
        checkOutput("hi_addr_0",     hi_imem_addr, 32'h0000_0000);
        checkOutput("hi_ifpc_fc",    hi_if_id_pc,  32'hFFFF_FFFC);
        checkOutput("hi_valid_fc",   hi_if_id_valid, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("hi_wait_addr",  hi_imem_addr, 32'h0000_0000);
        checkOutput("hi_wait_valid", hi_if_id_valid, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("hi_rst_req",    hi_imem_req,  32'h0);
        tick();
        checkOutput("hi_rst_pc",     hi_pc,        32'hFFFF_FFF8);
        checkOutput("hi_rst_npc",    hi_npc,       32'hFFFF_FFFC);
        checkOutput("hi_rst_valid",  hi_if_id_valid, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("hi_rel_req",    hi_imem_req,  32'h1);
        checkOutput("hi_rel_addr",   hi_imem_addr, 32'hFFFF_FFF8);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded at reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port stall, input, 1, load-use hold from the hazard logic; when high, PC, nPC and IF/ID hold.
REQ-005 SHALL have port redirect, input, 1, branch-taken/call/jmpl from decode; when high, nPC is loaded from redirect_target.
REQ-006 SHALL have port redirect_target, input, 32, the redirect destination byte address.
REQ-007 SHALL have port annul, input, 1, squashes the delay-slot instruction being fetched; valid only with redirect.
REQ-008 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-009 SHALL have port imem_addr, output, 32, the fetch address, equal to PC.
REQ-010 SHALL have port imem_ready, input, 1, memory acceptance; imem_data is valid in the same cycle.
REQ-011 SHALL have port imem_data, input, 32, the fetched instruction word.
REQ-012 SHALL have port if_id_instr, output, 32, the registered instruction to decode; 32'b0 means NOP.
REQ-013 SHALL have port if_id_pc, output, 32, the registered address of if_id_instr.
REQ-014 SHALL have port if_id_valid, output, 1, high when if_id_instr is a real, non-squashed instruction.
REQ-015 SHALL have ports pc and npc, each output, 32, the architectural PC/nPC for call/jmpl link values.

Function
REQ-016 SHALL implement an FSM with states RUN (request issued, first cycle) and WAIT (request outstanding, imem_ready low).
REQ-017 SHALL drive imem_req high in RUN and WAIT whenever stall is low; imem_addr SHALL stay stable while imem_req is high and imem_ready is low.
REQ-018 The accept cycle SHALL be imem_req & imem_ready & ~stall, with these actions:
- IF/ID <= {imem_data, PC, valid=1}
- PC <= nPC
- nPC <= effective redirect ? {target[31:2],2'b00} : nPC+4
- latency: data into IF/ID at the next edge
REQ-019 On a non-accept cycle with stall low, SHALL load IF/ID with {32'b0, PC, valid=0}, hold PC/nPC, and move to or stay in WAIT.
REQ-020 When stall is high, SHALL hold PC, nPC, IF/ID, the pending register and the state, drive imem_req low, and ignore redirect and annul.
REQ-021 SHALL capture redirect/annul/target arriving while stall is low and not accepting into a pending register (pend_v, pend_an, pend_tgt).
REQ-022 On the next accept, pending values SHALL act as the effective redirect; a fresh redirect in the same cycle SHALL override the pending one; pend_v SHALL clear on accept.
REQ-023 When annul is effective on an accept, SHALL load IF/ID instr with 32'b0 and valid=0; PC/nPC SHALL still advance per REQ-018.
REQ-024 SHALL ignore annul when no redirect is effective.
REQ-025 PC/nPC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 0); redirect_target[1:0] SHALL be forced to 00.

Reset
REQ-026 While rst_n is low at a clock edge, SHALL set:
- PC=RESET_PC, nPC=RESET_PC+4
- if_id_instr=0, if_id_pc=0, if_id_valid=0
- pend_v=0, state=RUN, imem_req=0
REQ-027 Reset asserted mid-WAIT SHALL abandon the outstanding request, and imem_req SHALL drop in the same cycle, combinationally from rst_n.

Structure
REQ-028 A shared package SHALL hold NOP_INSTR=32'h0, INSTR_W=32, and the FSM state enum.
REQ-029 SHALL contain one sub-module, fetch_pc_next, holding the combinational nPC/redirect/pending selection; all registers SHALL stay in fetch_unit.

Verification
REQ-030 The bench SHALL cover reset then imem_ready held high: imem_addr 0,4,8,C on consecutive cycles; if_id_pc lags by one cycle; valid=1.
REQ-031 The bench SHALL cover redirect=1, target=0x100 while accepting at PC=8: delay slot at 0xC is fetched, then 0x100, then 0x104.
REQ-032 The bench SHALL cover the same case as REQ-031 with annul=1: the 0xC slot reaches IF/ID as instr=0, valid=0; the next fetch is 0x100.
REQ-033 The bench SHALL cover imem_ready low for 3 cycles with redirect=1 to 0x200 pulsed in cycle 1: imem_addr stable, three bubbles, then the accept applies the 0x200 redirect.
REQ-034 The bench SHALL cover stall=1 for 2 cycles with redirect=1 asserted: PC, IF/ID and imem_req=0 hold, redirect is ignored, and the sequence resumes unchanged.
REQ-035 The bench SHALL cover RESET_PC=32'hFFFF_FFF8: fetches go FFFF_FFF8, FFFF_FFFC, 0000_0000; then rst_n low mid-WAIT gives PC=RESET_PC and imem_req=0.
